// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: walks an active-low column, synchronises and debounces
// the row matrix per frame, and reports single-key presses over valid/ready.
module keypad_scanner #(
  parameter int ROWS     = 4,
  parameter int COLS     = 4,
  parameter int SCAN_DIV = 50000,
  parameter int DEBOUNCE = 4,
  parameter int KEY_W    = $clog2(ROWS*COLS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [ROWS-1:0]  row,
  output logic [COLS-1:0]  col,
  output logic [KEY_W-1:0] key_code,
  output logic             key_valid,
  input  logic             key_ready,
  output logic             key_down,
  output logic             multi_key,
  output logic             overrun
);

  localparam int N  = ROWS*COLS;
  localparam int SW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(COLS);
  localparam int NW = $clog2(N+1);

  typedef enum logic [1:0] {ST_IDLE, ST_HELD, ST_MULTI} state_t;

  logic [ROWS-1:0]  row_meta_q, row_meta_d;
  logic [ROWS-1:0]  row_sync_q, row_sync_d;
  logic             run_q, run_d;
  logic [SW-1:0]    slot_q, slot_d;
  logic [CW-1:0]    colidx_q, colidx_d;
  logic [N-1:0]     raw_q, raw_d;
  logic [N-1:0]     prev_q, prev_d;
  logic [N-1:0]     deb_q, deb_d;
  logic [3:0]       stable_q, stable_d;
  logic             eval_q, eval_d;
  state_t           state_q, state_d;
  logic [KEY_W-1:0] held_q, held_d;
  logic [KEY_W-1:0] code_q, code_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;

  logic             slot_end;
  logic             frame_end;
  logic [NW-1:0]    n_keys;
  logic [KEY_W-1:0] one_idx;
  logic             press_evt;

  // Row synchroniser and column walk
  always_comb begin
    row_meta_d = row;
    row_sync_d = row_meta_q;
    run_d      = 1'b1;
    slot_end   = run_q && (slot_q == SW'(SCAN_DIV-1));
    frame_end  = slot_end && (colidx_q == CW'(COLS-1));
    slot_d     = slot_q;
    colidx_d   = colidx_q;
    if (run_q) begin
      if (slot_end) begin
        slot_d   = '0;
        colidx_d = (colidx_q == CW'(COLS-1)) ? '0 : colidx_q + CW'(1);
      end else begin
        slot_d = slot_q + SW'(1);
      end
    end
    col = run_q ? ~(COLS'(1) << colidx_q) : '1;
  end

  // Snapshot capture and whole-matrix debounce at frame end
  always_comb begin
    raw_d    = raw_q;
    prev_d   = prev_q;
    deb_d    = deb_q;
    stable_d = stable_q;
    eval_d   = frame_end;
    if (slot_end) begin
      raw_d[int'(colidx_q)*ROWS +: ROWS] = ~row_sync_q;
    end
    if (frame_end) begin
      if (raw_d == prev_q) begin
        stable_d = (stable_q >= 4'(DEBOUNCE)) ? 4'(DEBOUNCE) : stable_q + 4'd1;
      end else begin
        stable_d = 4'd1;
      end
      prev_d = raw_d;
      if (stable_d == 4'(DEBOUNCE)) begin
        deb_d = raw_d;
      end
    end
  end

  // Key count and index of the (last found) pressed key in the debounced matrix
  always_comb begin
    n_keys  = '0;
    one_idx = '0;
    for (int c = 0; c < COLS; c++) begin
      for (int r = 0; r < ROWS; r++) begin
        if (deb_q[c*ROWS + r]) begin
          n_keys  = n_keys + NW'(1);
          one_idx = KEY_W'(r*COLS + c);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      held_q  <= '0;
    end else begin
      state_q <= state_d;
      held_q  <= held_d;
    end
  end

  always_comb begin
    state_d = state_q;
    held_d  = held_q;
    if (eval_q) begin
      case (state_q)
        ST_IDLE: begin
          if (n_keys == NW'(1)) begin
            state_d = ST_HELD;
            held_d  = one_idx;
          end else if (n_keys > NW'(1)) begin
            state_d = ST_MULTI;
          end
        end
        ST_HELD: begin
          if (n_keys == '0) begin
            state_d = ST_IDLE;
          end else if (n_keys == NW'(1)) begin
            held_d = one_idx;
          end else begin
            state_d = ST_MULTI;
          end
        end
        ST_MULTI: begin
          if (n_keys == '0) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    key_down  = (state_q == ST_HELD);
    multi_key = (state_q == ST_MULTI);
    press_evt = eval_q && (n_keys == NW'(1)) &&
                ((state_q == ST_IDLE) || ((state_q == ST_HELD) && (one_idx != held_q)));
  end

  // Event register: a press while an unaccepted event is pending is dropped
  always_comb begin
    code_d  = code_q;
    valid_d = valid_q && !key_ready;
    ovr_d   = 1'b0;
    if (press_evt) begin
      if (!valid_q || key_ready) begin
        code_d  = one_idx;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
    key_code  = code_q;
    key_valid = valid_q;
    overrun   = ovr_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_meta_q <= '1;
      row_sync_q <= '1;
      run_q      <= 1'b0;
      slot_q     <= '0;
      colidx_q   <= '0;
      raw_q      <= '0;
      prev_q     <= '0;
      deb_q      <= '0;
      stable_q   <= '0;
      eval_q     <= 1'b0;
      code_q     <= '0;
      valid_q    <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      row_meta_q <= row_meta_d;
      row_sync_q <= row_sync_d;
      run_q      <= run_d;
      slot_q     <= slot_d;
      colidx_q   <= colidx_d;
      raw_q      <= raw_d;
      prev_q     <= prev_d;
      deb_q      <= deb_d;
      stable_q   <= stable_d;
      eval_q     <= eval_d;
      code_q     <= code_d;
      valid_q    <= valid_d;
      ovr_q      <= ovr_d;
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a frame-level keypad model predicts press events
// and levels; a negedge monitor scores accepted events against a queue.
module tb_keypad_scanner;
  localparam int ROWS     = 4;
  localparam int COLS     = 4;
  localparam int SCAN_DIV = 4;
  localparam int DEBOUNCE = 2;
  localparam int N        = ROWS*COLS;
  localparam int KEY_W    = $clog2(N);
  localparam int FRAME    = COLS*SCAN_DIV;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [ROWS-1:0]  row;
  logic [COLS-1:0]  col;
  logic [KEY_W-1:0] key_code;
  logic             key_valid;
  logic             key_ready = 1'b0;
  logic             key_down;
  logic             multi_key;
  logic             overrun;

  logic [N-1:0] pressed = '0;  // bit r*COLS+c set = key held

  int n_cmp  = 0;
  int n_fail = 0;
  int exp_q[$];
  int ovr_seen = 0;

  // Frame-level model state
  logic [N-1:0] m_prev, m_deb;
  int m_stable, m_held, m_evt, ovr_exp;
  bit m_multi, nx_down, nx_multi, e_down, e_multi, e_valid;

  always #5 clk = ~clk;

  // Keypad matrix: a held key pulls its row low while its column is driven low
  always_comb begin
    row = '1;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (pressed[r*COLS + c] && !col[c]) row[r] = 1'b0;
  end

  keypad_scanner #(
    .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)
  ) dut (
    .clk(clk), .reset(reset), .row(row), .col(col),
    .key_code(key_code), .key_valid(key_valid), .key_ready(key_ready),
    .key_down(key_down), .multi_key(multi_key), .overrun(overrun)
  );

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (key_valid && key_ready) begin
        if (exp_q.size() == 0) check("unexpected_event", int'(key_code), -1);
        else check("event_code", int'(key_code), exp_q.pop_front());
      end
      if (overrun) ovr_seen++;
    end
  end

  task automatic model_reset();
    m_prev = '0; m_deb = '0; m_stable = 0; m_held = -1; m_multi = 0;
    m_evt = -1; nx_down = 0; nx_multi = 0; e_down = 0; e_multi = 0; e_valid = 0;
    exp_q.delete();
  endtask

  // Called at the start of a frame (#1 after its first clock edge)
  task automatic run_frame(input logic [N-1:0] keys, input bit rdy);
    int n, k;
    pressed   = keys;
    key_ready = rdy;
    // Outcome of the previous frame's evaluation lands in this frame's first cycle
    e_down  = nx_down;
    e_multi = nx_multi;
    if (m_evt >= 0) begin
      if (e_valid && !rdy) ovr_exp++;
      else begin
        exp_q.push_back(m_evt);
        e_valid = 1;
      end
    end
    if (rdy) e_valid = 0;
    m_evt = -1;
    if (keys == m_prev) m_stable = (m_stable < DEBOUNCE) ? m_stable + 1 : DEBOUNCE;
    else m_stable = 1;
    m_prev = keys;
    if (m_stable == DEBOUNCE) m_deb = keys;
    n = 0; k = 0;
    for (int i = 0; i < N; i++) if (m_deb[i]) begin n++; k = i; end
    if (n == 0) begin m_multi = 0; m_held = -1; end
    else if (!m_multi) begin
      if (n >= 2) begin m_multi = 1; m_held = -1; end
      else begin
        if (m_held != k) m_evt = k;
        m_held = k;
      end
    end
    nx_down  = (m_held >= 0);
    nx_multi = m_multi;
    for (int i = 0; i < FRAME; i++) begin
      check("col", int'(col), 'hF ^ (1 << (i / SCAN_DIV)));
      @(posedge clk); #1;
    end
    check("key_down", int'(key_down), int'(e_down));
    check("multi_key", int'(multi_key), int'(e_multi));
    check("key_valid", int'(key_valid), int'(e_valid));
    check("overrun_count", ovr_seen, ovr_exp);
  endtask

  function automatic logic [N-1:0] kbit(input int idx);
    logic [N-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_col"}, int'(col), 'hF);
    check({tag, "_key_code"}, int'(key_code), 0);
    check({tag, "_key_valid"}, int'(key_valid), 0);
    check({tag, "_key_down"}, int'(key_down), 0);
    check({tag, "_multi_key"}, int'(multi_key), 0);
    check({tag, "_overrun"}, int'(overrun), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] keys;
    int kind, hold, a, b;
    ovr_exp = 0;
    model_reset();
    #2 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("reset");
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;

    repeat (2) run_frame('0, 1);

    // Key r=2,c=1 (code 9) held with consumer stalled, then accepted, then released
    repeat (3) run_frame(kbit(9), 0);
    check("hold9_valid", int'(key_valid), 1);
    check("hold9_code", int'(key_code), 9);
    repeat (3) run_frame(kbit(9), 1);
    check("hold9_accepted", int'(key_valid), 0);
    repeat (3) run_frame('0, 1);

    // Bouncing key 0, then stable
    for (int i = 0; i < 5; i++) run_frame((i % 2 == 0) ? kbit(0) : '0, 1);
    repeat (3) run_frame(kbit(0), 1);
    repeat (3) run_frame('0, 1);

    // Key 5, add key 10, drop key 10, release all
    repeat (3) run_frame(kbit(5), 1);
    repeat (3) run_frame(kbit(5) | kbit(10), 1);
    check("multi_level", int'(multi_key), 1);
    repeat (3) run_frame(kbit(5), 1);
    check("multi_sticky", int'(multi_key), 1);
    repeat (3) run_frame('0, 1);

    // Overrun: key 3 pending, key 7 lost
    repeat (3) run_frame(kbit(3), 0);
    repeat (3) run_frame('0, 0);
    repeat (3) run_frame(kbit(7), 0);
    check("ovr_valid", int'(key_valid), 1);
    check("ovr_code", int'(key_code), 3);
    check("ovr_pulses", ovr_seen, 1);
    run_frame(kbit(7), 1);
    repeat (3) run_frame('0, 1);

    // Reset mid-frame with an event pending
    repeat (3) run_frame(kbit(6), 0);
    check("pre_reset_valid", int'(key_valid), 1);
    repeat (5) @(posedge clk);
    #2 reset = 1'b1;
    #1 check_reset_outputs("midreset");
    model_reset();
    pressed = '0;
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    repeat (3) run_frame('0, 1);

    // Randomised key segments
    for (int s = 0; s < 150; s++) begin
      kind = $urandom_range(0, 3);
      hold = $urandom_range(1, 4);
      a = $urandom_range(0, N-1);
      b = $urandom_range(0, N-1);
      for (int f = 0; f < hold; f++) begin
        case (kind)
          0: keys = '0;
          1: keys = kbit(a);
          2: keys = kbit(a) | kbit(b);
          default: keys = kbit($urandom_range(0, N-1)) & {N{1'($urandom_range(0, 1))}};
        endcase
        run_frame(keys, $urandom_range(0, 3) != 0);
      end
    end
    repeat (4) run_frame('0, 1);
    check("pending_events", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
